// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial word add/sub datapath.
package serial_arith_pkg;

  // Sequencer states: wait for operands, stream bits, present result.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } serial_state_e;

  // Operation select encoding on in_sub.
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage : serial_arith_pkg

// File: rtl/serial_fa_cell.sv
// One-bit full-adder cell with a registered carry, built from bitwise gates only.
// sum and carry_out are combinational from a, b and the stored carry; the
// stored carry advances to carry_out every cycle unless load is asserted.
module serial_fa_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic carry_init,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_out
);

  logic carry_q;
  logic half_sum;

  assign half_sum  = a ^ b;
  assign sum       = half_sum ^ carry_q;
  assign carry_out = (a & b) | (carry_q & half_sum);

  // Carry register: cleared by reset, preset by load, otherwise ripples forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= carry_init;
    end else begin
      carry_q <= carry_out;
    end
  end

endmodule : serial_fa_cell

// File: rtl/serial_word_add_sub.sv
// Word-level wrapper around a bit-serial full adder: accepts parallel A/B and
// an add/sub select, streams the operands LSB-first through the cell, rebuilds
// the sum word and reports carry-out and signed overflow over a valid/ready pair.
module serial_word_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  serial_state_e state_q, state_d;

  logic [WIDTH-1:0] shift_a_q;
  logic [WIDTH-1:0] shift_b_q;
  // Holds the first WIDTH-1 sum bits; the final bit is merged in at capture.
  logic [WIDTH-2:0] partial_q;
  logic [WIDTH-2:0] partial_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  logic accept;
  logic last_bit;
  logic fa_load;
  logic fa_carry_init;
  logic fa_sum;
  logic fa_cout;
  logic fa_cin;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_ready & in_valid;
  assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  // The cell carry is parked at 0 outside SHIFT and preset to in_sub on
  // accept, which supplies the +1 of the two's-complement subtraction.
  assign fa_load       = (state_q != ST_SHIFT);
  assign fa_carry_init = accept & (in_sub == SUB);

  serial_fa_cell u_fa_cell (
    .clk        (clk),
    .rst        (rst),
    .load       (fa_load),
    .carry_init (fa_carry_init),
    .a          (shift_a_q[0]),
    .b          (shift_b_q[0]),
    .sum        (fa_sum),
    .carry_out  (fa_cout)
  );

  // Carry into the current bit, recovered from the cell's own sum output.
  assign fa_cin = shift_a_q[0] ^ shift_b_q[0] ^ fa_sum;

  // Result shift register: new sum bit enters at the top, older bits move down.
  assign partial_d[WIDTH-2] = fa_sum;
  generate
    for (genvar gi = 0; gi < WIDTH - 2; gi++) begin : g_partial
      assign partial_d[gi] = partial_q[gi+1];
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: accept -> WIDTH shift cycles -> hold until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)  state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit)  state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand load on accept, bit streaming in SHIFT, result capture on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_a_q <= '0;
      shift_b_q <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      shift_a_q <= in_a;
      shift_b_q <= (in_sub == SUB) ? ~in_b : in_b;
      cnt_q     <= '0;
    end else if (state_q == ST_SHIFT) begin
      shift_a_q <= {1'b0, shift_a_q[WIDTH-1:1]};
      shift_b_q <= {1'b0, shift_b_q[WIDTH-1:1]};
      partial_q <= partial_d;
      if (last_bit) begin
        cnt_q   <= '0;
        sum_q   <= {fa_sum, partial_q};
        carry_q <= fa_cout;
        ovf_q   <= fa_cin ^ fa_cout;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_sum      = sum_q;
  assign out_carry    = carry_q;
  assign out_overflow = ovf_q;

endmodule : serial_word_add_sub

// File: tb/tb_serial_word_add_sub.sv
// Directed + random bench for serial_word_add_sub (WIDTH=8) with a result scoreboard.
module tb_serial_word_add_sub;
  import serial_arith_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_overflow;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  exp_t sb[$];

  serial_word_add_sub #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sub       (in_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carry    (out_carry),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Reference arithmetic on full-width integers.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   r;
    exp_t         e;
    bb    = sub ? ~b : b;
    r     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    e.sum = r[W-1:0];
    e.c   = r[W];
    e.v   = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  // Present one operand word; caller is at a negedge. Returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input exp_t e, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout_fail("in_ready_wait");
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    if (push) sb.push_back(e);
    @(negedge clk);
    accept_cyc = cyc;
    in_valid   = 1'b0;
    in_a       = W'($urandom);
    in_b       = W'($urandom);
    in_sub     = 1'($urandom);
    check("accepted_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Wait for the result, optionally stall, then consume and compare against the scoreboard.
  task automatic receive(input int hold, input bit poke);
    int   lat = 0;
    exp_t e;
    logic [W+1:0] snap;
    while (!out_valid && lat < 100) begin
      if (poke) begin
        in_valid = 1'b1;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      timeout_fail("out_valid_wait");
      in_valid = 1'b0;
      return;
    end
    check("latency", 32'(lat), 32'(W));
    snap = {out_sum, out_carry, out_overflow};
    for (int i = 0; i < hold; i++) begin
      if (poke) in_valid = 1'b1;
      @(negedge clk);
      check("hold_stable", 32'({out_sum, out_carry, out_overflow}), 32'(snap));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    if (sb.size() == 0) begin
      timeout_fail("scoreboard_empty");
    end else begin
      e = sb.pop_front();
      check("sum", 32'(out_sum), 32'(e.sum));
      check("carry", 32'(out_carry), 32'(e.c));
      check("overflow", 32'(out_overflow), 32'(e.v));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           hold, prev_hold, prev_accept;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_ovf", 32'(out_overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed add/sub cases with literal expectations
    send(8'h05, 8'h03, ADD, exp_t'{8'h08, 1'b0, 1'b0}, 1'b1); receive(0, 1'b0);
    send(8'h7F, 8'h01, ADD, exp_t'{8'h80, 1'b0, 1'b1}, 1'b1); receive(0, 1'b0);
    send(8'hFF, 8'h01, ADD, exp_t'{8'h00, 1'b1, 1'b0}, 1'b1); receive(0, 1'b0);
    send(8'h03, 8'h05, SUB, exp_t'{8'hFE, 1'b0, 1'b0}, 1'b1); receive(0, 1'b0);
    send(8'h80, 8'h01, SUB, exp_t'{8'h7F, 1'b1, 1'b1}, 1'b1); receive(0, 1'b0);

    // Backpressure for 5 cycles, with in_valid pulsed during SHIFT and DONE
    send(8'h5A, 8'h33, ADD, exp_t'{8'h8D, 1'b0, 1'b1}, 1'b1); receive(5, 1'b1);
    send(8'h10, 8'h20, SUB, exp_t'{8'hF0, 1'b0, 1'b0}, 1'b1); receive(0, 1'b0);

    // Reset on the 4th SHIFT cycle aborts the operation
    send(8'h12, 8'h34, ADD, exp_t'{8'h46, 1'b0, 1'b0}, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_sum", 32'(out_sum), 32'd0);
    send(8'h01, 8'h01, ADD, exp_t'{8'h02, 1'b0, 1'b0}, 1'b1); receive(0, 1'b0);

    // Random back-to-back traffic with random consumer stalls
    prev_hold   = 1;
    prev_accept = 0;
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rs   = 1'($urandom);
      hold = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      send(ra, rb, rs, model(ra, rb, rs), 1'b1);
      if (prev_hold == 0) check("init_interval", 32'(accept_cyc - prev_accept), 32'(W + 2));
      prev_accept = accept_cyc;
      receive(hold, 1'($urandom));
      prev_hold = hold;
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_word_add_sub
